// File: rtl/sig_mon.sv
// Pulse-train monitor: synchronises sig_in, measures rise-to-rise period and high
// width, qualifies each period against nominal +/- tolerance and tracks lock.
module sig_mon #(
    parameter int CNT_W      = 16,
    parameter int PERIOD_NOM = 100,
    parameter int PERIOD_TOL = 2,
    parameter int WIDTH_MAX  = 4,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_width,
    output logic             meas_valid,
    output logic             locked,
    output logic             missing,
    output logic             bad_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(PERIOD_NOM + PERIOD_TOL + 1);
    localparam logic [CNT_W-1:0] C_WMAX    = CNT_W'(WIDTH_MAX);
    localparam logic [CNT_W-1:0] C_LOCK    = CNT_W'(LOCK_CNT);
    localparam logic signed [CNT_W:0] C_NOM_S     = (CNT_W+1)'(PERIOD_NOM);
    localparam logic signed [CNT_W:0] C_TOL_S     = (CNT_W+1)'(PERIOD_TOL);
    localparam logic signed [CNT_W:0] C_TOL_NEG_S = -C_TOL_S;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == C_MAX) begin
            sat_inc = C_MAX;
        end else begin
            sat_inc = v + C_ONE;
        end
    endfunction

    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_pcnt, r_wcnt, r_whold, r_gcnt;
    state_t           r_state;
    logic [CNT_W-1:0] r_meas_period, r_meas_width;
    logic             r_meas_valid, r_locked, r_missing, r_bad_pulse;

    logic                    w_rise, w_fall;
    logic signed [CNT_W:0]   w_diff;
    logic                    w_good;
    state_t                  w_state_nx;
    logic [CNT_W-1:0]        w_gcnt_nx;
    logic                    w_eval, w_miss;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_diff = $signed({1'b0, r_pcnt}) - C_NOM_S;
    assign w_good = (w_diff >= C_TOL_NEG_S) && (w_diff <= C_TOL_S)
                 && (r_whold >= C_ONE) && (r_whold <= C_WMAX);

    // Synchroniser, period/width counters and width holding register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_pcnt  <= C_ZERO;
            r_wcnt  <= C_ZERO;
            r_whold <= C_ZERO;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_rise) begin
                r_pcnt  <= C_ONE;
                r_wcnt  <= C_ONE;
                r_whold <= C_ZERO;
            end else begin
                r_pcnt <= sat_inc(r_pcnt);
                if (r_s2) begin
                    r_wcnt <= sat_inc(r_wcnt);
                end else begin
                    r_wcnt <= r_wcnt;
                end
                // r_whold was cleared at the rise, so a fall only ever latches this pulse
                if (w_fall) begin
                    r_whold <= r_wcnt;
                end else begin
                    r_whold <= r_whold;
                end
            end
        end
    end

    // Next-state, good-run count and event decode; a rise pre-empts the timeout
    always_comb begin
        w_state_nx = r_state;
        w_gcnt_nx  = r_gcnt;
        w_eval     = 1'b0;
        w_miss     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nx = ST_ARMED;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_ARMED, ST_TRACK, ST_LOCK: begin
                if (w_rise) begin
                    w_eval = 1'b1;
                    if (!w_good) begin
                        w_state_nx = ST_ARMED;
                        w_gcnt_nx  = C_ZERO;
                    end else if (r_state == ST_ARMED) begin
                        w_gcnt_nx  = C_ONE;
                        w_state_nx = (C_LOCK == C_ONE) ? ST_LOCK : ST_TRACK;
                    end else if (r_state == ST_TRACK) begin
                        w_gcnt_nx  = r_gcnt + C_ONE;
                        w_state_nx = ((r_gcnt + C_ONE) == C_LOCK) ? ST_LOCK : ST_TRACK;
                    end else begin
                        w_state_nx = ST_LOCK;
                    end
                end else if (r_pcnt == C_TIMEOUT) begin
                    w_miss     = 1'b1;
                    w_state_nx = ST_IDLE;
                    w_gcnt_nx  = C_ZERO;
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gcnt_nx  = C_ZERO;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_gcnt        <= C_ZERO;
            r_meas_period <= C_ZERO;
            r_meas_width  <= C_ZERO;
            r_meas_valid  <= 1'b0;
            r_locked      <= 1'b0;
            r_missing     <= 1'b0;
            r_bad_pulse   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_gcnt       <= w_gcnt_nx;
            r_meas_valid <= w_eval;
            r_bad_pulse  <= w_eval & ~w_good;
            r_missing    <= w_miss;
            r_locked     <= (w_state_nx == ST_LOCK);
            if (w_eval) begin
                r_meas_period <= r_pcnt;
                r_meas_width  <= r_whold;
            end else begin
                r_meas_period <= r_meas_period;
                r_meas_width  <= r_meas_width;
            end
        end
    end

    assign meas_period = r_meas_period;
    assign meas_width  = r_meas_width;
    assign meas_valid  = r_meas_valid;
    assign locked      = r_locked;
    assign missing     = r_missing;
    assign bad_pulse   = r_bad_pulse;

endmodule

// File: tb/tb_sig_mon.sv
// Scoreboard bench for sig_mon: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares on every meas_valid / missing strobe.
module tb_sig_mon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] meas_period, meas_width;
    logic        meas_valid, locked, missing, bad_pulse;

    sig_mon dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .meas_period(meas_period), .meas_width(meas_width),
        .meas_valid(meas_valid), .locked(locked),
        .missing(missing), .bad_pulse(bad_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_miss;
        int period;
        int width;
        bit bad;
        bit lck;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, int'(meas_period), 0);
        check({tag, "_width"},  int'(meas_width), 0);
        check({tag, "_valid"},  int'(meas_valid), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_missing"}, int'(missing), 0);
        check({tag, "_bad"},    int'(bad_pulse), 0);
    endtask

    task automatic exp_meas(input int p, input int w, input bit b, input bit l);
        sb.push_back('{1'b0, p, w, b, l});
    endtask

    task automatic exp_miss();
        sb.push_back('{1'b1, 103, 0, 1'b0, 1'b0});
    endtask

    // One pulse of w cycles high, next rise gap cycles after this one
    task automatic pulse(input int w, input int gap);
        sig_in = 1'b1;
        repeat (w) @(negedge clk);
        sig_in = 1'b0;
        repeat (gap - w) @(negedge clk);
    endtask

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (meas_valid) begin
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_meas: got period %0d width %0d, required no measurement", meas_period, meas_width);
            end else begin
                e = sb.pop_front();
                check("event_is_meas", int'(e.is_miss), 0);
                check("meas_period", int'(meas_period), e.period);
                check("meas_width", int'(meas_width), e.width);
                check("bad_pulse", int'(bad_pulse), int'(e.bad));
                check("locked", int'(locked), int'(e.lck));
                check("missing_with_meas", int'(missing), 0);
            end
        end else if (missing) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_missing: got missing=1, required 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("event_is_missing", int'(e.is_miss), 1);
                check("missing_delay", cyc - last_valid_cyc, e.period);
                check("locked_after_missing", int'(locked), 0);
                check("bad_with_missing", int'(bad_pulse), 0);
            end
        end else if (bad_pulse) begin
            n_chk++;
            n_fail++;
            $display("FAIL bad_without_valid: got bad_pulse=1, required 0 (cycle %0d)", cyc);
        end
    end

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Nominal train: arm, then four good periods to lock
        pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b1); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b1); pulse(2, 103);
        // 103 drops lock; 98,98,98,102 relock
        exp_meas(103, 2, 1'b1, 1'b0); pulse(2, 98);
        exp_meas(98, 2, 1'b0, 1'b0);  pulse(2, 98);
        exp_meas(98, 2, 1'b0, 1'b0);  pulse(2, 98);
        exp_meas(98, 2, 1'b0, 1'b0);  pulse(2, 102);
        exp_meas(102, 2, 1'b0, 1'b1); pulse(2, 100);
        // Train stops while locked: missing 103 cycles later, back to IDLE
        exp_meas(100, 2, 1'b0, 1'b1); exp_miss(); pulse(2, 200);
        // Restart re-arms only; then over-wide pulses
        pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(5, 100);
        exp_meas(100, 5, 1'b1, 1'b0); pulse(5, 100);
        exp_meas(100, 5, 1'b1, 1'b0); pulse(5, 100);
        exp_meas(100, 5, 1'b1, 1'b0); pulse(2, 103);
        // Rise exactly on the timeout cycle: bad period, no missing, stays ARMED
        exp_meas(103, 2, 1'b1, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b1); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b1); pulse(2, 100);
        // Reset for one cycle while locked and mid-pulse
        exp_meas(100, 2, 1'b0, 1'b1);
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        sig_in = 1'b0;
        check_zero("midreset");
        repeat (30) @(negedge clk);
        // Relock after reset: arm plus four good periods
        pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b0); pulse(2, 100);
        exp_meas(100, 2, 1'b0, 1'b1); pulse(2, 20);
        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_locked", int'(locked), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
